// File: rtl/ps2_host_sender.sv
// PS/2 host-to-device command sender: inhibits the bus and issues a request-to-send.
// It then shifts out one byte, its odd parity and a stop bit on device clock falls, and collects the device ACK.
module ps2_host_sender #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int REQ_CYCLES     = 10,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       send,
   input  logic [7:0] cmd,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_ok,
   output logic       timeout
);

   localparam int PH_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [PH_W-1:0] INH_LAST = PH_W'(INHIBIT_CYCLES - 1);
   localparam logic [PH_W-1:0] REQ_LAST = PH_W'(REQ_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      TX,
      WAIT_IDLE,
      DONE
   } state_t;

   state_t          state;
   logic [7:0]      cmd_r;
   logic            parity;
   logic [3:0]      bit_idx;
   logic [PH_W-1:0] ph_cnt;
   logic [TO_W-1:0] to_cnt;

   logic clk_meta, clk_sync, clk_prev;
   logic dat_meta, dat_sync;
   logic fall;
   logic next_oe;

   // Synchronisers idle high so a released bus never looks like a clock fall after reset.
   always_ff @(posedge clk) begin
      if (clr) begin
         clk_meta <= 1'b1;
         clk_sync <= 1'b1;
         clk_prev <= 1'b1;
         dat_meta <= 1'b1;
         dat_sync <= 1'b1;
      end else begin
         clk_meta <= ps2_clk_in;
         clk_sync <= clk_meta;
         clk_prev <= clk_sync;
         dat_meta <= ps2_dat_in;
         dat_sync <= dat_meta;
      end
   end

   assign fall = clk_prev & ~clk_sync;

   // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      next_oe = 1'b0;
      if (bit_idx < 4'd8)
         next_oe = ~cmd_r[bit_idx[2:0]];
      else if (bit_idx == 4'd8)
         next_oe = ~parity;
   end

   // NOTE: sequential state uses non-blocking assignments only; the command register is reset
   // along with everything else because it is a handful of flops, not a memory.
   always_ff @(posedge clk) begin
      if (clr) begin
         state      <= IDLE;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         ack_ok     <= 1'b0;
         timeout    <= 1'b0;
         cmd_r      <= '0;
         parity     <= 1'b0;
         bit_idx    <= '0;
         ph_cnt     <= '0;
         to_cnt     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               ps2_clk_oe <= 1'b0;
               ps2_dat_oe <= 1'b0;
               busy       <= 1'b0;
               if (send) begin
                  cmd_r      <= cmd;
                  parity     <= ~^cmd;
                  ack_ok     <= 1'b0;
                  timeout    <= 1'b0;
                  ph_cnt     <= '0;
                  ps2_clk_oe <= 1'b1;
                  busy       <= 1'b1;
                  state      <= INHIBIT;
               end
            end

            INHIBIT: begin
               if (ph_cnt == INH_LAST) begin
                  ph_cnt     <= '0;
                  ps2_dat_oe <= 1'b1;
                  state      <= REQ;
               end else begin
                  ph_cnt <= ph_cnt + 1'b1;
               end
            end

            REQ: begin
               if (ph_cnt == REQ_LAST) begin
                  ph_cnt     <= '0;
                  ps2_clk_oe <= 1'b0;
                  bit_idx    <= '0;
                  to_cnt     <= '0;
                  state      <= TX;
               end else begin
                  ph_cnt <= ph_cnt + 1'b1;
               end
            end

            TX: begin
               if (fall) begin
                  to_cnt <= '0;
                  if (bit_idx == 4'd10) begin
                     ack_ok     <= ~dat_sync;
                     ps2_dat_oe <= 1'b0;
                     state      <= WAIT_IDLE;
                  end else begin
                     ps2_dat_oe <= next_oe;
                     bit_idx    <= bit_idx + 1'b1;
                  end
               end else if (to_cnt == TO_LIMIT) begin
                  ps2_clk_oe <= 1'b0;
                  ps2_dat_oe <= 1'b0;
                  timeout    <= 1'b1;
                  ack_ok     <= 1'b0;
                  done       <= 1'b1;
                  state      <= DONE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end

            WAIT_IDLE: begin
               ps2_clk_oe <= 1'b0;
               ps2_dat_oe <= 1'b0;
               if (clk_sync && dat_sync) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else if (fall) begin
                  to_cnt <= '0;
               end else if (to_cnt == TO_LIMIT) begin
                  timeout <= 1'b1;
                  ack_ok  <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end

            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
